// File: rtl/conv1d_pkg.sv
// Shared constants and elaboration-time helpers for the conv1d MAC datapath.
// csa_levels/csa_rows_at describe the shape of a 3:2 Wallace reduction so that
// generate loops can size each level without hand-written tables.
package conv1d_pkg;

  localparam int WIDTH_DATA = 16;

  // Row count entering level lvl when starting from n rows.
  function automatic int csa_rows_at(input int n, input int lvl);
    int rows;
    rows = n;
    for (int i = 0; i < lvl; i++) begin
      rows = 2 * (rows / 3) + (rows % 3);
    end
    return rows;
  endfunction

  // Number of 3:2 levels needed to bring n rows down to two.
  function automatic int csa_levels(input int n);
    int rows;
    int lvls;
    rows = n;
    lvls = 0;
    while (rows > 2) begin
      rows = 2 * (rows / 3) + (rows % 3);
      lvls++;
    end
    return lvls;
  endfunction

endpackage

// File: rtl/wallace_ppa_pipe_csa_row.sv
// One W-bit row of 3:2 carry-save cells. The carry comes out already moved to
// its true weight (shifted left by one); the MSB carry falls off because all
// arithmetic downstream is mod 2^W.
module csa_row #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry_shifted
);

  assign sum = a ^ b ^ c;

  assign carry_shifted = {(a[W-2:0] & b[W-2:0]) |
                          (a[W-2:0] & c[W-2:0]) |
                          (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/wallace_ppa_pipe.sv
// Pipelined Wallace-tree compressor: N_PP partial products -> sum/carry pair
// (carry weight-aligned), optional registered CPA. A single advance signal
// moves every stage at once, so the whole pipe stalls together.
module wallace_ppa_pipe
  import conv1d_pkg::*;
#(
  parameter int W         = WIDTH_DATA * 2,
  parameter int N_PP      = 8,
  parameter int REG_EVERY = 2,
  parameter int FINAL_ADD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W*N_PP-1:0] pp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      sum,
  output logic [W-1:0]      carry,
  output logic [W-1:0]      result
);

  localparam int L     = csa_levels(N_PP);
  localparam int S     = (L + REG_EVERY - 1) / REG_EVERY;
  localparam int S_TOT = S + FINAL_ADD;

  logic             adv;
  logic [S_TOT-1:0] vld_p;
  logic [2*W-1:0]   tree_out;

  assign out_valid = vld_p[S_TOT-1];
  assign adv       = !out_valid || out_ready;
  // Reset wins over a stalled output, so the block is always ready during reset.
  assign in_ready  = adv || rst;

  if (S_TOT == 1) begin : g_vld1
    // Single-stage pipe: valid simply follows the accepted input.
    always_ff @(posedge clk) begin
      if (rst)      vld_p <= '0;
      else if (adv) vld_p <= in_valid;
    end
  end else begin : g_vldn
    // Valid shift chain; bubbles move with the data and are never squeezed out.
    always_ff @(posedge clk) begin
      if (rst)      vld_p <= '0;
      else if (adv) vld_p <= {vld_p[S_TOT-2:0], in_valid};
    end
  end

  for (genvar lv = 0; lv < L; lv++) begin : g_lvl
    localparam int NI  = csa_rows_at(N_PP, lv);
    localparam int NO  = csa_rows_at(N_PP, lv + 1);
    localparam int NT  = NI / 3;
    localparam int NR  = NI % 3;
    localparam bit REG = ((lv + 1) % REG_EVERY == 0) || (lv == L - 1);
    localparam bit CLR = (lv == L - 1) && (FINAL_ADD == 0);

    logic [NI*W-1:0] din;
    logic [NO*W-1:0] nxt;
    logic [NO*W-1:0] dout;

    if (lv == 0) begin : g_src
      assign din = pp;
    end else begin : g_src
      assign din = g_lvl[lv-1].dout;
    end

    // Each triple becomes (sum, carry) in place; leftover rows follow unchanged.
    for (genvar t = 0; t < NT; t++) begin : g_csa
      csa_row #(.W(W)) u_csa (
        .a             (din[(3*t)*W +: W]),
        .b             (din[(3*t+1)*W +: W]),
        .c             (din[(3*t+2)*W +: W]),
        .sum           (nxt[(2*t)*W +: W]),
        .carry_shifted (nxt[(2*t+1)*W +: W])
      );
    end

    if (NR > 0) begin : g_pass
      assign nxt[(2*NT)*W +: NR*W] = din[(3*NT)*W +: NR*W];
    end

    if (REG) begin : g_reg
      logic [NO*W-1:0] rows_p;
      // ---- stage boundary: rows hold while stalled; only the output stage clears on reset
      always_ff @(posedge clk) begin
        if (CLR && rst) rows_p <= '0;
        else if (adv)   rows_p <= nxt;
      end
      assign dout = rows_p;
    end else begin : g_comb
      assign dout = nxt;
    end
  end

  assign tree_out = g_lvl[L-1].dout;

  if (FINAL_ADD != 0) begin : g_fa
    logic [W-1:0] sum_pf;
    logic [W-1:0] carry_pf;
    logic [W-1:0] result_pf;
    // ---- CPA stage: sum/carry are re-registered so they stay aligned with result
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_pf    <= '0;
        carry_pf  <= '0;
        result_pf <= '0;
      end else if (adv) begin
        sum_pf    <= tree_out[W-1:0];
        carry_pf  <= tree_out[2*W-1:W];
        result_pf <= tree_out[W-1:0] + tree_out[2*W-1:W];
      end
    end
    assign sum    = sum_pf;
    assign carry  = carry_pf;
    assign result = result_pf;
  end else begin : g_nofa
    assign sum    = tree_out[W-1:0];
    assign carry  = tree_out[2*W-1:W];
    assign result = '0;
  end

endmodule

// File: tb/tb_wallace_ppa_pipe.sv
// Scoreboard bench for wallace_ppa_pipe: instance A (N_PP=8, no CPA) and
// instance B (N_PP=16, with CPA). Expected values are plain sums of the
// partial products modulo 2^32.
module tb_wallace_ppa_pipe;

  localparam int W  = 32;
  localparam int NA = 8;
  localparam int NB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic            in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [NA*W-1:0] pp_a;
  logic [W-1:0]    sum_a, carry_a, result_a;

  logic            in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [NB*W-1:0] pp_b;
  logic [W-1:0]    sum_b, carry_b, result_b;

  wallace_ppa_pipe #(.W(W), .N_PP(NA), .REG_EVERY(2), .FINAL_ADD(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .pp(pp_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .sum(sum_a), .carry(carry_a),
    .result(result_a)
  );

  wallace_ppa_pipe #(.W(W), .N_PP(NB), .REG_EVERY(2), .FINAL_ADD(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .pp(pp_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .sum(sum_b), .carry(carry_b),
    .result(result_b)
  );

  int total = 0;
  int bad   = 0;
  int got_a = 0;
  int got_b = 0;

  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  logic [W-1:0] e_a;
  logic [W-1:0] e_b;

  function automatic logic [W-1:0] pp_total(input logic [NB*W-1:0] v, input int n);
    logic [W-1:0] acc;
    acc = '0;
    for (int k = 0; k < n; k++) acc = acc + v[k*W +: W];
    return acc;
  endfunction

  function automatic logic [NB*W-1:0] rand_pp();
    logic [NB*W-1:0] v;
    for (int k = 0; k < NB; k++) v[k*W +: W] = $urandom;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor A: every transferred output beat must match the oldest accepted input.
  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready_a) begin
      total++;
      if (exp_a.size() == 0) begin
        bad++;
        $display("FAIL a_extra_beat: got sum=%h carry=%h want no beat", sum_a, carry_a);
      end else begin
        e_a = exp_a.pop_front();
        got_a++;
        check("a_sum_plus_carry", sum_a + carry_a, e_a);
        check("a_carry_lsb", {31'b0, carry_a[0]}, 32'd0);
        check("a_result_tied", result_a, 32'd0);
      end
    end
  end

  // Monitor B: CPA result and the sum/carry pair must both agree with the model.
  always @(negedge clk) begin
    if (!rst && out_valid_b && out_ready_b) begin
      total++;
      if (exp_b.size() == 0) begin
        bad++;
        $display("FAIL b_extra_beat: got result=%h want no beat", result_b);
      end else begin
        e_b = exp_b.pop_front();
        got_b++;
        check("b_result", result_b, e_b);
        check("b_sum_plus_carry", sum_b + carry_b, e_b);
        check("b_carry_lsb", {31'b0, carry_b[0]}, 32'd0);
      end
    end
  end

  task automatic drive_a(input logic v, input logic [NA*W-1:0] d);
    in_valid_a = v;
    pp_a       = d;
    @(negedge clk);
    if (v && in_ready_a && !rst) exp_a.push_back(pp_total({{(NB-NA)*W{1'b0}}, d}, NA));
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic v, input logic [NB*W-1:0] d, output logic acc);
    in_valid_b = v;
    pp_b       = d;
    @(negedge clk);
    acc = v && in_ready_b && !rst;
    if (acc) exp_b.push_back(pp_total(d, NB));
    @(posedge clk);
    #1;
  endtask

  task automatic measure_a(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid_a) break;
    end
  endtask

  task automatic measure_b(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid_b) break;
    end
  endtask

  task automatic drain_a();
    for (int i = 0; i < 40 && exp_a.size() != 0; i++) @(posedge clk);
    #1;
    check("a_drain_left", exp_a.size(), 32'd0);
  endtask

  task automatic drain_b();
    for (int i = 0; i < 60 && exp_b.size() != 0; i++) @(posedge clk);
    #1;
    check("b_drain_left", exp_b.size(), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NB*W-1:0] v;
    logic [NA*W-1:0] va;
    logic [W-1:0]    hs, hc;
    logic            acc;
    int              lat, base;

    rst = 1'b1;
    in_valid_a = 1'b0; pp_a = '0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; pp_b = '0; out_ready_b = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid_a", {31'b0, out_valid_a}, 32'd0);
    check("rst_sum_a", sum_a, 32'd0);
    check("rst_carry_a", carry_a, 32'd0);
    check("rst_in_ready_a", {31'b0, in_ready_a}, 32'd1);
    check("rst_result_b", result_b, 32'd0);
    check("rst_out_valid_b", {31'b0, out_valid_b}, 32'd0);
    rst = 1'b0;
    out_ready_a = 1'b1;

    // All partial products = 1: latency 2, sum+carry = 8.
    for (int k = 0; k < NA; k++) va[k*W +: W] = 32'h1;
    drive_a(1'b1, va);
    in_valid_a = 1'b0;
    measure_a(lat);
    check("a_latency", lat, 32'd2);
    check("a_ones_total", sum_a + carry_a, 32'd8);
    @(posedge clk); #1;

    // All partial products = all ones: wraps to FFFF_FFF8.
    va = '1;
    drive_a(1'b1, va);
    in_valid_a = 1'b0;
    measure_a(lat);
    check("a_ff_total", sum_a + carry_a, 32'hFFFF_FFF8);
    check("a_ff_carry_lsb", {31'b0, carry_a[0]}, 32'd0);
    @(posedge clk); #1;
    drain_a();

    // 20 random beats back to back, full throughput.
    base = got_a;
    for (int i = 0; i < 20; i++) begin
      v  = rand_pp();
      va = v[NA*W-1:0];
      drive_a(1'b1, va);
    end
    in_valid_a = 1'b0;
    drain_a();
    check("a_stream_count", got_a - base, 32'd20);

    // Fill the pipe against a blocked output and hold for 5 cycles.
    out_ready_a = 1'b0;
    base = got_a;
    for (int i = 0; i < 5; i++) begin
      v  = rand_pp();
      va = v[NA*W-1:0];
      drive_a(1'b1, va);
    end
    in_valid_a = 1'b0;
    @(negedge clk);
    hs = sum_a;
    hc = carry_a;
    check("a_stall_full", {31'b0, out_valid_a}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("a_stall_in_ready", {31'b0, in_ready_a}, 32'd0);
      check("a_stall_valid", {31'b0, out_valid_a}, 32'd1);
      check("a_stall_sum", sum_a, hs);
      check("a_stall_carry", carry_a, hc);
    end
    @(posedge clk); #1;
    out_ready_a = 1'b1;
    drain_a();
    check("a_stall_count", got_a - base, 32'd2);

    // Reset with two beats in flight and the output blocked: both are discarded.
    base = got_a;
    v = rand_pp(); va = v[NA*W-1:0]; drive_a(1'b1, va);
    v = rand_pp(); va = v[NA*W-1:0]; drive_a(1'b1, va);
    in_valid_a  = 1'b0;
    out_ready_a = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    check("a_rst_in_ready_during", {31'b0, in_ready_a}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_a.delete();
    check("a_rst_out_valid", {31'b0, out_valid_a}, 32'd0);
    check("a_rst_sum", sum_a, 32'd0);
    check("a_rst_carry", carry_a, 32'd0);
    check("a_rst_in_ready", {31'b0, in_ready_a}, 32'd1);
    out_ready_a = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("a_rst_no_ghost", got_a - base, 32'd0);

    // Instance B: PP[k] = k -> 120 after ceil(6/2)+1 = 4 cycles.
    for (int k = 0; k < NB; k++) v[k*W +: W] = k;
    drive_b(1'b1, v, acc);
    in_valid_b = 1'b0;
    measure_b(lat);
    check("b_latency", lat, 32'd4);
    check("b_index_result", result_b, 32'd120);
    check("b_index_sum_carry", sum_b + carry_b, 32'd120);
    @(posedge clk); #1;
    drain_b();

    // Instance B random beats under random back-pressure.
    base = got_b;
    for (int i = 0; i < 12; i++) begin
      v   = rand_pp();
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
        out_ready_b = ($urandom_range(0, 3) != 0);
        drive_b(1'b1, v, acc);
      end
    end
    in_valid_b  = 1'b0;
    out_ready_b = 1'b1;
    drain_b();
    check("b_stream_count", got_b - base, 32'd13 - 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wallace_ppa_pipe.md
Name: wallace_ppa_pipe

Overview:
- Parametrised, pipelined Wallace-tree partial-product compressor for the conv1d MAC datapath.
- Reduces N_PP partial products of W bits to one sum/carry pair using 3:2 CSA levels, with pipeline registers every REG_EVERY levels.
- Uses a valid/ready stream handshake with full-pipeline stall.
- Carry output is already weight-aligned, so a downstream CPA computes sum + carry directly; an optional FINAL_ADD mode adds a registered CPA result.

Parameters:
- W, `WIDTH_DATA*2 (32): width of each partial product and of all outputs; all arithmetic is mod 2^W.
- N_PP, 8: number of partial products; legal values 3..32.
- REG_EVERY, 2: CSA levels between pipeline registers; legal values 1..L.
- FINAL_ADD, 0: 1 instantiates a registered W-bit carry-propagate add driving `result`; 0 ties `result` to 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  `pp` holds a valid operand set.
- in_ready  out  1  block accepts `pp` this cycle.
- pp  in  W*N_PP  partial products; PP[k] = pp[k*W +: W].
- out_valid  out  1  `sum`/`carry`/`result` are valid.
- out_ready  in  1  downstream accepts the output.
- sum  out  W  compressed sum vector.
- carry  out  W  compressed carry vector, pre-shifted left by 1 (bit 0 always 0).
- result  out  W  (sum + carry) mod 2^W when FINAL_ADD=1, else 0.

Behaviour:
- Reset:
  - One clk edge with rst=1 clears all stage valid bits, out_valid, sum, carry and result to 0.
  - in_ready is 1 during and after reset.
  - Reset mid-operation discards all in-flight data; out_valid is 0 from the first cycle after the reset edge.
- Level count: L = number of 3:2 levels to reduce N_PP rows to 2, where each level maps n rows to 2*floor(n/3) + (n mod 3). Examples: N_PP=8 gives L=4; N_PP=16 gives L=6; N_PP=3 gives L=1.
- Level rules:
  - Each level applies CSA rows to consecutive row triples.
  - Leftover rows (n mod 3) pass through unchanged.
  - Every carry row is shifted left by 1 with its MSB discarded before it feeds the next level.
- Pipeline:
  - S = ceil(L/REG_EVERY) register stages; the last stage is the output register.
  - Latency from the accept cycle (in_valid & in_ready) to out_valid is S cycles. Default: S=2.
  - FINAL_ADD=1 adds one stage: latency S+1. `sum`/`carry` are then delayed to stay aligned with `result`.
- Handshake:
  - adv = !out_valid | out_ready; in_ready = adv, combinational.
  - When adv=1, all stages (data and valid) shift by one; stage-0 valid loads in_valid.
  - When adv=0, every stage holds and the outputs stay bit-stable.
  - Bubbles are not collapsed while stalled.
  - Throughput is one operand set per cycle while out_ready=1.
  - Data registers load regardless of valid, but outputs are only meaningful while out_valid=1.
- Invariants:
  - (sum + carry) mod 2^W == (Σ PP[k]) mod 2^W for every output beat.
  - Output order equals input order; no beat is dropped or duplicated.
- Simultaneous events:
  - in_valid with out_valid & out_ready in the same cycle: both transfers occur.
  - rst overrides all handshake activity.

Decomposition:
- Shared package conv1d_pkg holds:
  - WIDTH_DATA;
  - constant function csa_levels(n), returning L;
  - constant function csa_rows_at(n, lvl), returning the row count at each level (used for generate bounds).
- Sub-module csa_row (W-bit row of CSA_3_2 cells):
  - Inputs a, b, c; outputs sum and carry_shifted.
  - carry_shifted = {cout[W-2:0], 1'b0}.
  - Instantiated per triple per level inside a generate.

Test Plan:
- W=32, N_PP=8, REG_EVERY=2, out_ready=1; all PP=32'h1 for one beat -> out_valid exactly 2 cycles after accept; sum+carry = 8.
- All PP=32'hFFFF_FFFF -> (sum+carry) mod 2^32 = 32'hFFFF_FFF8; carry[0]=0.
- Stream 20 random beats back-to-back with out_ready=1 -> 20 outputs in order, one per cycle, each matching the Σ PP model.
- out_ready=0 for 5 cycles while the pipe is full -> in_ready=0; sum/carry/out_valid unchanged; releasing resumes with no loss or duplication.
- Assert rst with 2 beats in flight -> next cycle out_valid=0, sum=carry=0, in_ready=1; those beats never appear.
- N_PP=16, FINAL_ADD=1, PP[k]=k -> result = 120; latency = ceil(6/2)+1 = 4 cycles.
